ysyx_25060173_imem_responder: RTL and testbench

Instruction-memory responder for the ysyx_25060173 core: the memory end of the instruction-fetch interface. It accepts one word-aligned fetch request at a time over a valid/ready handshake, waits a programmable number of cycles, and returns the 32-bit instruction over a second valid/ready handshake. A side-band loader port fills the array before and during simulation. Later this block will replace the core's directly driven `inst` input.

---
 rtl/ysyx_25060173_imem_responder_if.sv | 21 ++
 rtl/ysyx_25060173_imem_responder.sv | 104 ++++++++++
 tb/tb_ysyx_25060173_imem_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25060173_imem_responder_if.sv
// Fetch request/response handshake bundle between the core (master)
// and the instruction-memory responder (slave).
interface ysyx_25060173_imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/ysyx_25060173_imem_responder.sv
// Instruction-memory responder: one fetch at a time, fixed LATENCY, side-band loader.
// Define YSYX_25060173_IMEM_FAULT_EBREAK_EN to return ebreak instead of zero on faults.
module ysyx_25060173_imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_25060173_imem_responder_if.slave bus,
  input  logic                        ld_we,
  input  logic [ADDR_W-1:0]           ld_addr,
  input  logic [31:0]                 ld_data
);

`ifdef YSYX_25060173_IMEM_FAULT_EBREAK_EN
  localparam logic [31:0] FAULT_INST = 32'h0010_0073;
`else
  localparam logic [31:0] FAULT_INST = 32'h0000_0000;
`endif

  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_inst_q;
  logic        rsp_err_q;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [32:0]       offset;
  logic              fault;
  logic [ADDR_W-1:0] rd_idx;

  // 33-bit offset: addresses below BASE_ADDR wrap to huge values and fail the range test
  always_comb begin
    offset = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
    fault  = (bus.req_addr[1:0] != 2'b00) || (offset >= LIMIT);
    rd_idx = offset[ADDR_W+1:2];
  end

  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            // read sees pre-edge array contents, so a same-cycle loader write is not visible
            rsp_inst_q  <= fault ? FAULT_INST : mem[rd_idx];
            rsp_err_q   <= fault;
            cnt         <= 4'(LATENCY - 1);
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state       <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_inst  = rsp_inst_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_25060173_imem_responder.sv
// Bench for ysyx_25060173_imem_responder: four instances (LATENCY 2, 4, 1, 15)
// sharing one loader, driven by directed steps with a response scoreboard.
module tb_ysyx_25060173_imem_responder;

`ifdef YSYX_25060173_IMEM_FAULT_EBREAK_EN
  localparam logic [31:0] FAULT_INST = 32'h0010_0073;
`else
  localparam logic [31:0] FAULT_INST = 32'h0000_0000;
`endif
  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst        [NI];
  logic        req_valid  [NI];
  logic [31:0] req_addr   [NI];
  logic        rsp_ready  [NI];
  logic        req_ready_o[NI];
  logic        rsp_valid_o[NI];
  logic [31:0] rsp_inst_o [NI];
  logic        rsp_err_o  [NI];
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 4 : (k == 2) ? 1 : 15;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 15;
    ysyx_25060173_imem_responder_if bus ();
    assign bus.req_valid  = req_valid[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.rsp_ready  = rsp_ready[g];
    assign req_ready_o[g] = bus.req_ready;
    assign rsp_valid_o[g] = bus.rsp_valid;
    assign rsp_inst_o[g]  = bus.rsp_inst;
    assign rsp_err_o[g]   = bus.rsp_err;
    ysyx_25060173_imem_responder #(
      .DEPTH_WORDS(1024),
      .BASE_ADDR  (32'h8000_0000),
      .LATENCY    (L)
    ) dut (
      .clk    (clk),
      .rst    (rst[g]),
      .bus    (bus),
      .ld_we  (ld_we),
      .ld_addr(ld_addr),
      .ld_data(ld_data)
    );
  end

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } sb_t;
  sb_t sb[$];

  int passed = 0;
  int total  = 0;
  int last_acc [NI];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // Entered and left on a negedge; the instance is IDLE on exit.
  task automatic fetch(input int k, input logic [31:0] addr, input logic [31:0] exp_inst,
                       input logic exp_err, input int bp, input bit collide, input bit chk_rate);
    int  n;
    int  t_acc;
    sb_t e;
    req_valid[k] = 1'b1; req_addr[k] = addr; rsp_ready[k] = (bp == 0);
    n = 0;
    while (!req_ready_o[k] && n < 40) begin @(negedge clk); n++; end
    if (!req_ready_o[k]) begin
      chk("accept_timeout", 0, 1); req_valid[k] = 1'b0; return;
    end
    if (collide) begin ld_we = 1'b1; ld_addr = 10'd3; ld_data = 32'h3333_3333; end
    t_acc = cyc;
    if (chk_rate) chk("accept_spacing", 64'(t_acc - last_acc[k]), 64'(lat_of(k) + 1));
    last_acc[k] = t_acc;
    e.inst = exp_inst; e.err = exp_err; sb.push_back(e);
    @(negedge clk);
    req_valid[k] = 1'b0; req_addr[k] = $urandom; ld_we = 1'b0;
    n = 0;
    while (!rsp_valid_o[k] && n < 40) begin @(negedge clk); n++; end
    if (!rsp_valid_o[k]) begin
      chk("rsp_timeout", 0, 1); void'(sb.pop_front()); return;
    end
    chk("latency", 64'(cyc - t_acc), 64'(lat_of(k)));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_inst_stable", rsp_inst_o[k], sb[0].inst);
      chk("bp_valid_held", rsp_valid_o[k], 1);
      chk("bp_req_ready", req_ready_o[k], 0);
    end
    rsp_ready[k] = 1'b1;
    e = sb.pop_front();
    chk("rsp_inst", rsp_inst_o[k], e.inst);
    chk("rsp_err", rsp_err_o[k], e.err);
    @(negedge clk);
    chk("idle_req_ready", req_ready_o[k], 1);
    chk("idle_rsp_valid", rsp_valid_o[k], 0);
  endtask

  initial begin
    int seen;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_addr[k] = '0; rsp_ready[k] = 1'b0;
      last_acc[k] = 0;
    end
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_req_ready", req_ready_o[k], 0);
      chk("rst_rsp_valid", rsp_valid_o[k], 0);
      chk("rst_rsp_inst", rsp_inst_o[k], 0);
      chk("rst_rsp_err", rsp_err_o[k], 0);
    end
    load(10'd0, 32'h0010_0093);
    load(10'd1, 32'h0000_0073);
    load(10'd3, 32'h1111_1111);
    load(10'd5, 32'hCAFE_BABE);
    load(10'd1023, 32'h0BAD_F00D);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk("post_rst_req_ready", req_ready_o[k], 1);

    fetch(0, 32'h8000_0000, 32'h0010_0093, 1'b0, 0, 1'b0, 1'b0);
    fetch(0, 32'h8000_0004, 32'h0000_0073, 1'b0, 0, 1'b0, 1'b1);
    fetch(0, 32'h8000_0014, 32'hCAFE_BABE, 1'b0, 5, 1'b0, 1'b0);
    fetch(0, 32'h8000_0FFC, 32'h0BAD_F00D, 1'b0, 0, 1'b0, 1'b0);
    fetch(0, 32'h8000_0002, FAULT_INST,    1'b1, 0, 1'b0, 1'b0);
    fetch(0, 32'h7FFF_FFFC, FAULT_INST,    1'b1, 0, 1'b0, 1'b0);
    fetch(0, 32'h8000_1000, FAULT_INST,    1'b1, 0, 1'b0, 1'b0);
    fetch(0, 32'hFFFF_FFFC, FAULT_INST,    1'b1, 2, 1'b0, 1'b0);
    fetch(0, 32'h8000_000C, 32'h1111_1111, 1'b0, 0, 1'b1, 1'b0);
    fetch(0, 32'h8000_000C, 32'h3333_3333, 1'b0, 0, 1'b0, 1'b0);

    // reset one cycle after accept drops the pending fetch on the LATENCY=4 instance
    req_valid[1] = 1'b1; req_addr[1] = 32'h8000_0000; rsp_ready[1] = 1'b1;
    chk("rstmid_accept_ready", req_ready_o[1], 1);
    @(negedge clk);
    req_valid[1] = 1'b0; rst[1] = 1'b1;
    @(negedge clk);
    chk("rstmid_req_ready", req_ready_o[1], 0);
    chk("rstmid_rsp_valid", rsp_valid_o[1], 0);
    rst[1] = 1'b0;
    @(negedge clk);
    chk("rstmid_idle_ready", req_ready_o[1], 1);
    rsp_ready[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid_o[1]) seen++;
      @(negedge clk);
    end
    chk("rstmid_no_rsp", 64'(seen), 0);
    fetch(1, 32'h8000_0004, 32'h0000_0073, 1'b0, 0, 1'b0, 1'b0);

    for (int k = 2; k < NI; k++) begin
      fetch(k, 32'h8000_0000, 32'h0010_0093, 1'b0, 0, 1'b0, 1'b0);
      fetch(k, 32'h8000_0014, 32'hCAFE_BABE, 1'b0, 0, 1'b0, 1'b1);
      fetch(k, 32'h8000_0006, FAULT_INST,    1'b1, 0, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
